// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources,
// issuing a start pulse per grant and enforcing a baud-tick idle gap between frames.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
    output logic [NUM_REQ-1:0]        ack_out,
    output logic [NUM_REQ-1:0]        grant_out,
    input  logic                      baud_tick_in,
    output logic                      tx_start_out,
    output logic [DATA_W-1:0]         tx_data_out,
    input  logic                      tx_done_in,
    output logic                      busy_out
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;

    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  win_oh;

    // Search last+1, last+2, ... modulo NUM_REQ; the first pending request wins.
    always_comb begin
        int unsigned cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_in[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
        win_oh = NUM_REQ'(1) << win_idx;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        grant_d = grant_q;
        start_d = 1'b0;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ISSUE;
                    last_d  = win_idx;
                    grant_d = win_oh;
                    ack_d   = win_oh;
                    start_d = 1'b1;
                    data_d  = req_data_in[32'(win_idx) * DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A baud tick coinciding with done is not counted toward the gap.
                if (tx_done_in) begin
                    if (GAP_TICKS == 0) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(GAP_TICKS);
                    end
                end
            end
            GAP: begin
                if (baud_tick_in) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= PTR_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            start_q <= start_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign ack_out      = ack_q;
    assign grant_out    = grant_q;
    assign tx_start_out = start_q;
    assign tx_data_out  = data_q;
    assign busy_out     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level model predicts every
// cycle's outputs into a queue; a monitor on the falling edge pops and compares.
module tb_uart_tx_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned GAP  = 2;
    localparam int unsigned NCYC = 4000;
    localparam int unsigned NDIR = 120;

    logic              Clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_in;
    logic [NR*DW-1:0]  req_data_in;
    logic [NR-1:0]     ack_out;
    logic [NR-1:0]     grant_out;
    logic              baud_tick_in;
    logic              tx_start_out;
    logic [DW-1:0]     tx_data_out;
    logic              tx_done_in;
    logic              busy_out;

    always #5 Clk = ~Clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .GAP_TICKS(GAP)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .req_in       (req_in),
        .req_data_in  (req_data_in),
        .ack_out      (ack_out),
        .grant_out    (grant_out),
        .baud_tick_in (baud_tick_in),
        .tx_start_out (tx_start_out),
        .tx_data_out  (tx_data_out),
        .tx_done_in   (tx_done_in),
        .busy_out     (busy_out)
    );

    typedef struct {
        logic          busy;
        logic          start;
        logic [NR-1:0] ack;
        logic [NR-1:0] grant;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", name, mon_cyc, got, want);
        end
    endtask

    // First pending requester after the last granted one, wrapping modulo NR.
    function automatic int pick(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= int'(NR); k++) begin
            int i;
            i = (last + k) % int'(NR);
            if (r[i]) return i;
        end
        return -1;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            mon_cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("busy",  32'(busy_out),     32'(e.busy));
                check("start", 32'(tx_start_out), 32'(e.start));
                check("ack",   32'(ack_out),      32'(e.ack));
                check("grant", 32'(grant_out),    32'(e.grant));
                check("data",  32'(tx_data_out),  32'(e.data));
            end
        end
    end

    // Model of the shared transmitter: who owns it and what still has to happen
    int            owner;
    bit            issuing;
    bit            waiting;
    int            frame_left;
    int            gap_left;
    int            last;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] rd [NR];
    int            pend [NR];

    initial begin : stimulus
        exp_t e;
        int   w;
        bit   directed;

        owner = -1; issuing = 0; waiting = 0; frame_left = 0; gap_left = 0;
        last = int'(NR) - 1; exp_data = '0;
        for (int i = 0; i < int'(NR); i++) begin
            rd[i]   = DW'(8'h10 + i);
            pend[i] = 0;
        end
        req_in = '1;
        baud_tick_in = 1'b0;
        tx_done_in = 1'b0;
        reset = 1'b1;

        for (int unsigned n = 0; n < NCYC; n++) begin
            directed = (n < NDIR);

            // Reset: at start, then occasionally while a frame is in flight
            reset = (n < 3) || (!directed && owner >= 0 && $urandom_range(0, 59) == 0);

            // Requesters: after ack, drop or present a fresh byte; idle ones raise at random
            if (!directed) begin
                for (int i = 0; i < int'(NR); i++) begin
                    if (pend[i] > 0) begin
                        pend[i]--;
                        if (pend[i] == 0) begin
                            if ($urandom_range(0, 1) == 0) begin
                                req_in[i] = 1'b0;
                            end else begin
                                rd[i] = DW'($urandom);
                            end
                        end
                    end else if (!req_in[i] && $urandom_range(0, 3) == 0) begin
                        req_in[i] = 1'b1;
                        rd[i]     = DW'($urandom);
                    end
                end
            end
            for (int i = 0; i < int'(NR); i++) begin
                req_data_in[i*DW +: DW] = rd[i];
            end

            // Transmitter: done after a random frame length, plus stray pulses elsewhere
            if (waiting) begin
                tx_done_in = (frame_left == 0);
                if (frame_left > 0) frame_left--;
            end else begin
                tx_done_in = ($urandom_range(0, 7) == 0);
            end
            baud_tick_in = ($urandom_range(0, 2) == 0);

            // Predict the outputs that follow this edge
            e.start = 1'b0;
            e.ack   = '0;
            if (reset) begin
                owner = -1; issuing = 0; waiting = 0; gap_left = 0;
                last = int'(NR) - 1; exp_data = '0;
            end else if (owner < 0) begin
                w = pick(req_in, last);
                if (w >= 0) begin
                    owner      = w;
                    last       = w;
                    issuing    = 1;
                    exp_data   = rd[w];
                    frame_left = int'($urandom_range(0, 6));
                    if (!directed) pend[w] = 2;
                    e.start = 1'b1;
                    e.ack   = NR'(1) << w;
                end
            end else if (issuing) begin
                issuing = 0;
                waiting = 1;
            end else if (waiting) begin
                if (tx_done_in) begin
                    waiting = 0;
                    if (GAP == 0) owner = -1;
                    else gap_left = int'(GAP);
                end
            end else if (baud_tick_in) begin
                gap_left--;
                if (gap_left == 0) owner = -1;
            end
            e.busy  = (owner >= 0);
            e.grant = (owner >= 0) ? (NR'(1) << owner) : '0;
            e.data  = exp_data;
            exp_q.push_back(e);

            @(posedge Clk);
            #1;
        end

        reset = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares a single UART transmit datapath (transmitter FSM plus shift register) between `NUM_REQ` byte-producing requesters. It selects one pending requester, latches its byte, and issues a one-cycle start pulse to the transmitter. It then waits for frame completion and enforces a programmable idle gap, measured in baud ticks, before the next grant. It sits between the on-chip byte sources and the transmitter FSM's `tx_start_in` and data-load path.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `DATA_W`, 8: byte width.
- `GAP_TICKS`, 2: idle baud ticks enforced between frames; 0..15. A value of 0 means no gap.
- `Clk  in  1`: single system clock; all logic rises on posedge.
- `reset  in  1`: synchronous, active-high. Sampled on posedge `Clk`.
- `req_in  in  NUM_REQ`: level request, one bit per requester; held until acked.
- `req_data_in  in  NUM_REQ*DATA_W`: requester i's byte in bits `[i*DATA_W +: DATA_W]`; stable while `req_in[i]`=1.
- `ack_out  out  NUM_REQ`: one-hot, one-cycle pulse; the byte of that requester has been accepted.
- `grant_out  out  NUM_REQ`: one-hot owner of the transmitter from grant through end of gap; 0 in IDLE.
- `baud_tick_in  in  1`: one-cycle pulse per bit period, from the baud generator.
- `tx_start_out  out  1`: one-cycle start pulse to the transmitter FSM.
- `tx_data_out  out  DATA_W`: latched byte to the transmitter load path; held from grant until the next grant.
- `tx_done_in  in  1`: one-cycle pulse from the transmitter at the end of the stop bit.
- `busy_out  out  1`: 1 in every state except IDLE.

## Operation
- Four states: IDLE, ISSUE, WAIT_DONE, GAP. State, pointer, counter and all outputs are registered.
- Round-robin pointer `last` holds the index of the last granted requester. The search order is `last+1, last+2, …` modulo `NUM_REQ`, and the first set `req_in` bit wins.
- IDLE:
  - If `req_in` is nonzero, the following happen on that edge: the winner is selected, `grant_out` is set one-hot, `tx_data_out` is latched from the winner's slice, `last` is set to the winner, and the state moves to ISSUE.
  - If `req_in` is zero, the block stays in IDLE.
- ISSUE, exactly one cycle:
  - `tx_start_out`=1 and `ack_out[winner]`=1.
  - Move to WAIT_DONE.
  - `tx_done_in` is ignored in this state.
- WAIT_DONE:
  - Hold until `tx_done_in`=1.
  - Then go to GAP, loading gap counter = `GAP_TICKS`; if `GAP_TICKS`=0, go directly to IDLE.
  - `req_in` changes have no effect in this state.
- GAP:
  - The counter decrements on each `baud_tick_in`.
  - When a tick arrives with counter=1, go to IDLE.
  - Non-tick cycles hold the counter.
- When leaving GAP or WAIT_DONE for IDLE, `grant_out` is cleared.
- Requester protocol: drop `req_in[i]` (or present the next byte) on the cycle after `ack_out[i]`. A request still asserted in IDLE is treated as a new byte.
- Width rules:
  - `last` is `$clog2(NUM_REQ)` bits; increment wraps from `NUM_REQ-1` to 0, including non-power-of-2 values.
  - The gap counter is 4 bits.

## Timing
- Reset values:
  - state IDLE; `last`=`NUM_REQ-1`, so requester 0 has first priority.
  - `ack_out`=0, `grant_out`=0, `tx_start_out`=0, `tx_data_out`=0, `busy_out`=0, gap counter=0.
- Latency:
  - A request sampled in IDLE on edge N produces `tx_start_out`/`ack_out` high in the cycle after edge N, for exactly one cycle.
  - `tx_data_out` is valid from that same cycle.
- A `tx_done_in` pulse on edge M gives IDLE (when `GAP_TICKS`=0) after edge M. The next `tx_start_out` comes at the earliest one cycle later.
- Minimum spacing between `tx_start_out` pulses: 3 cycles plus frame time plus `GAP_TICKS` baud ticks.
- Simultaneous events:
  - `baud_tick_in` and `tx_done_in` in the same cycle of WAIT_DONE: the tick is not counted toward the gap.
  - `tx_done_in` outside WAIT_DONE is ignored.
- Reset mid-frame, in any state: on the next edge the block returns to its reset values. Any in-flight grant is abandoned with no ack re-issue; the transmitter is reset by the same `reset`.

## Test plan
- Single requester: `req_in`=0001, byte 0xA5, `GAP_TICKS`=2 → `tx_start_out` and `ack_out`=0001 one cycle after the request, `tx_data_out`=0xA5. After `tx_done_in`, IDLE is entered only after the 2nd `baud_tick_in`.
- All four requesting continuously from reset → grant order 0,1,2,3,0 with bytes 0x10,0x11,0x12,0x13,0x10. Each `ack_out` is exactly one cycle.
- Fairness: requesters 1 and 3 held high, 1 granted first → next grant is 3, then 1. Requester 1 never gets two grants in a row while 3 is waiting.
- `GAP_TICKS`=0, requester 2 continuously high → `tx_start_out` 2 cycles after each `tx_done_in`. `busy_out` drops for exactly one cycle.
- `tx_done_in` pulsed during ISSUE and during GAP → ignored. Stray `baud_tick_in` during WAIT_DONE does not shorten the gap.
- `reset` asserted during WAIT_DONE and during GAP → all outputs 0 next cycle and state IDLE. With `req_in`=1000 afterwards, requester 3 is granted and `last` has restarted from 3.
